snake_engine: RTL and testbench
===============================

Name: snake_engine

Overview:
- Parametrised snake body engine. Holds up to MAX_LEN segment cell coordinates in a circular buffer.
- Advances the snake one cell per `tick` strobe, with direction control, growth, wall detection and serial self-collision detection.
- Provides a registered cell-query port so the VGA pixel renderer can ask "is cell (x,y) head/body?".
- Sits between the PS/2 key decoder / frame-tick logic and the pixel colour mux.

Parameters:
GRID_W, 64, grid width in cells; XW = $clog2(GRID_W)
GRID_H, 48, grid height in cells; YW = $clog2(GRID_H)
MAX_LEN, 32, maximum segment count (buffer depth); LW = $clog2(MAX_LEN+1)
INIT_LEN, 4, length after reset/start; legal range 2..min(MAX_LEN, GRID_W)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  pulse: (re)initialise snake and enter RUN
tick  in  1  pulse: advance one step (one frame)
dir_valid  in  1  qualifies dir
dir  in  2  00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
grow  in  1  pulse: request one-segment growth on next step
q_x  in  XW  query cell x
q_y  in  YW  query cell y
q_hit_head  out  1  query result: cell is head (1-cycle latency)
q_hit_body  out  1  query result: cell is a non-head live segment (1-cycle latency)
head_x  out  XW  current head x
head_y  out  YW  current head y
length  out  LW  current live segment count
busy  out  1  high in MOVE/SCAN; ticks are dropped while high
dead  out  1  high in DEAD
died  out  1  one-cycle pulse on entry to DEAD

Behaviour:
- Clocking and reset: one clock, `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values:
  - state IDLE; length = INIT_LEN; committed and pending dir = right.
  - Segment k at (INIT_LEN-1-k, GRID_H/2); head_ptr = 0; grow_pend = 0.
  - All outputs 0 except head_x = INIT_LEN-1, head_y = GRID_H/2, length = INIT_LEN.
- Storage: seg_x/seg_y arrays of depth MAX_LEN. Segment k lives at index (head_ptr - k) mod MAX_LEN. Only k < length is live.
- States: IDLE, RUN, MOVE, SCAN, DEAD.
- IDLE/DEAD: `start` reloads the reset layout (dir = right, grow_pend = 0) and goes to RUN next cycle. `tick` is ignored.
- Direction handling:
  - `dir_valid` is accepted in any state into pending_dir.
  - It is rejected if it is the reverse of the committed dir.
  - pending_dir is committed at the next accepted tick.
  - Same-cycle `dir_valid` + `tick`: the new dir applies to this step if legal.
- Growth: `grow` sets sticky grow_pend, cleared when a step consumes it.
- RUN + `tick`:
  - Compute next head from the committed dir.
  - Off-grid when x==0 going left, x==GRID_W-1 going right, y==0 going up, or y==GRID_H-1 going down.
  - If off-grid: go to DEAD, pulse `died`, and leave positions unchanged.
  - Otherwise go to MOVE.
- MOVE (1 cycle):
  - head_ptr = head_ptr+1 mod MAX_LEN; write the new head there.
  - If grow_pend and length < MAX_LEN: length+1. If grow_pend and length == MAX_LEN: growth is discarded.
  - grow_pend cleared in both cases. Go to SCAN with i = 1.
- SCAN:
  - One compare per cycle: segment i vs head, i = 1..length-1 (length-1 cycles).
  - On a match: go to DEAD and pulse `died`.
  - After i = length-1 with no match: go to RUN.
  - A cell just vacated by the tail is legal.
- Ticks arriving in MOVE/SCAN/IDLE/DEAD are dropped, not queued.
- `start` in any non-IDLE state restarts immediately (wins over a same-cycle tick or collision).
- Query path: q_hit_head = (q == segment 0); q_hit_body = any live k ≥ 1 matches. Both are registered with 1-cycle latency and valid in every state (the body stays visible when dead).
- `died` is high for exactly one cycle. `dead` stays high until `start`.
- Reset asserted mid-MOVE/SCAN returns all state to the reset values asynchronously.

Decomposition:
- snake_pkg:
  - DIR_UP/DOWN/LEFT/RIGHT encodings.
  - State enum.
  - opposite(dir) function.
- Sub-module snake_cell_match: parallel MAX_LEN-way compare of (q_x, q_y) against live segments, registered outputs. Instantiated once for the query port.

Test Plan:
(All with defaults 64x48, INIT_LEN = 4.)
1. Reset release -> head (3,24), length 4, dead = 0. q = (0,24) gives q_hit_body = 1 and q = (3,24) gives q_hit_head = 1, each one cycle later.
2. start, then 3 ticks spaced > 5 cycles -> head (6,24). Query (2,24) gives 0 (tail moved); query (3,24) gives body 1.
3. dir = left while moving right, then tick -> rejected, head x+1. dir = up, then tick -> head y-1. Tick during busy -> dropped, head unchanged.
4. grow + tick -> length 5, tail cell retained. At length == MAX_LEN, grow + tick -> length stays MAX_LEN.
5. Drive right until head x = 63, then tick -> `died` one-cycle pulse, dead = 1, head stays (63,24). start -> head (3,24), RUN.
6. Length 5, moving right; step up, left, down -> collision with segment 4 during SCAN -> `died` pulse, dead = 1.

Source files
------------

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Purpose  : Shared definitions for the snake body engine: direction
//            encodings, controller state enum and the direction-reversal
//            helper.
// Revision : 1.0 - initial release
// ============================================================================
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;   // y-1
    localparam logic [1:0] DIR_DOWN  = 2'b01;   // y+1
    localparam logic [1:0] DIR_LEFT  = 2'b10;   // x-1
    localparam logic [1:0] DIR_RIGHT = 2'b11;   // x+1

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_MOVE = 3'd2,
        ST_SCAN = 3'd3,
        ST_DEAD = 3'd4
    } state_t;

    // Direction that would make the head fold back onto segment 1.
    function automatic logic [1:0] opposite(input logic [1:0] d);
        logic [1:0] r;
        case (d)
            DIR_UP:   r = DIR_DOWN;
            DIR_DOWN: r = DIR_UP;
            DIR_LEFT: r = DIR_RIGHT;
            default:  r = DIR_LEFT;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_cell_match.sv
`default_nettype none
// ============================================================================
// Module   : snake_cell_match
// Purpose  : Parallel compare of a query cell against every buffer slot of
//            the snake body, with registered head / body hit flags.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            seg_x, seg_y      - circular segment buffer contents
//            head_ptr          - buffer slot holding segment 0
//            length            - live segment count
//            q_x, q_y          - query cell
//            q_hit_head        - query cell is segment 0 (1-cycle latency)
//            q_hit_body        - query cell is a live segment k>=1
// Revision : 1.0 - initial release
// ============================================================================
module snake_cell_match
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int XW      = 6,
    parameter int YW      = 6,
    parameter int PW      = 5,
    parameter int LW      = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [MAX_LEN-1:0][XW-1:0]    seg_x,
    input  logic [MAX_LEN-1:0][YW-1:0]    seg_y,
    input  logic [PW-1:0]                 head_ptr,
    input  logic [LW-1:0]                 length,
    input  logic [XW-1:0]                 q_x,
    input  logic [YW-1:0]                 q_y,
    output logic                          q_hit_head,
    output logic                          q_hit_body
);

    // One extra bit so head_ptr + MAX_LEN - j never overflows.
    localparam int KW = PW + 1;

    logic [MAX_LEN-1:0] head_m;
    logic [MAX_LEN-1:0] body_m;
    logic               hit_head_d, hit_head_q;
    logic               hit_body_d, hit_body_q;

    for (genvar j = 0; j < MAX_LEN; j++) begin : g_cmp
        logic [KW-1:0] age;     // segment index k stored in slot j
        logic          live;
        logic          same;

        always_comb begin
            if ({1'b0, head_ptr} >= KW'(j)) begin
                age = {1'b0, head_ptr} - KW'(j);
            end else begin
                age = {1'b0, head_ptr} + KW'(MAX_LEN - j);
            end
        end

        assign live      = int'(age) < int'(length);
        assign same      = (seg_x[j] == q_x) && (seg_y[j] == q_y);
        assign head_m[j] = same && (age == '0);
        assign body_m[j] = same && live && (age != '0);
    end

    assign hit_head_d = |head_m;
    assign hit_body_d = |body_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_head_q <= 1'b0;
            hit_body_q <= 1'b0;
        end else begin
            hit_head_q <= hit_head_d;
            hit_body_q <= hit_body_d;
        end
    end

    assign q_hit_head = hit_head_q;
    assign q_hit_body = hit_body_q;

endmodule
`default_nettype wire

// File: rtl/snake_engine.sv
`default_nettype none
// ============================================================================
// Module   : snake_engine
// Purpose  : Snake body engine. Keeps segment coordinates in a circular
//            buffer, advances one cell per tick with direction control,
//            growth, wall detection and serial self-collision scan, and
//            answers registered cell queries for the pixel renderer.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            start             - (re)initialise snake and enter RUN
//            tick              - advance one step
//            dir_valid, dir    - direction request
//            grow              - request one-segment growth
//            q_x, q_y          - query cell
//            q_hit_head/body   - query result (1-cycle latency)
//            head_x, head_y    - current head cell
//            length            - live segment count
//            busy              - step in progress (ticks dropped)
//            dead, died        - dead level / one-cycle death pulse
// Revision : 1.0 - initial release
// ============================================================================
module snake_engine
    import snake_pkg::*;
#(
    parameter  int GRID_W   = 64,
    parameter  int GRID_H   = 48,
    parameter  int MAX_LEN  = 32,
    parameter  int INIT_LEN = 4,
    localparam int XW       = $clog2(GRID_W),
    localparam int YW       = $clog2(GRID_H),
    localparam int LW       = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          tick,
    input  logic          dir_valid,
    input  logic [1:0]    dir,
    input  logic          grow,
    input  logic [XW-1:0] q_x,
    input  logic [YW-1:0] q_y,
    output logic          q_hit_head,
    output logic          q_hit_body,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic          busy,
    output logic          dead,
    output logic          died
);

    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // ------------------------------------------------------------------
    // Start-of-game layout: segment k at (INIT_LEN-1-k, GRID_H/2), stored
    // at slot (0 - k) mod MAX_LEN so that head_ptr starts at 0.
    // ------------------------------------------------------------------
    function automatic logic [MAX_LEN-1:0][XW-1:0] layout_x();
        logic [MAX_LEN-1:0][XW-1:0] v;
        v = '0;
        for (int k = 0; k < INIT_LEN; k++) begin
            v[PW'((MAX_LEN - k) % MAX_LEN)] = XW'(INIT_LEN - 1 - k);
        end
        return v;
    endfunction

    function automatic logic [MAX_LEN-1:0][YW-1:0] layout_y();
        logic [MAX_LEN-1:0][YW-1:0] v;
        for (int k = 0; k < MAX_LEN; k++) begin
            v[k] = YW'(GRID_H / 2);
        end
        return v;
    endfunction

    // Slot holding segment n, i.e. (p - n) mod MAX_LEN.
    function automatic logic [PW-1:0] ring_back(input logic [PW-1:0] p,
                                                input logic [LW-1:0] n);
        int t;
        t = int'(p) - int'(n);
        if (t < 0) begin
            t = t + MAX_LEN;
        end
        return PW'(t);
    endfunction

    state_t                      state_q, state_d;
    logic [1:0]                  dir_q, dir_d;       // committed direction
    logic [1:0]                  pend_q, pend_d;     // pending direction
    logic                        grow_pend_q, grow_pend_d;
    logic [PW-1:0]               head_ptr_q, head_ptr_d;
    logic [LW-1:0]               length_q, length_d;
    logic [LW-1:0]               scan_i_q, scan_i_d;
    logic [MAX_LEN-1:0][XW-1:0]  seg_x_q, seg_x_d;
    logic [MAX_LEN-1:0][YW-1:0]  seg_y_q, seg_y_d;
    logic                        died_q, died_d;

    logic [XW-1:0] cur_x, nxt_x;
    logic [YW-1:0] cur_y, nxt_y;
    logic          dir_ok;
    logic [1:0]    eff_dir;
    logic [1:0]    step_dir;
    logic          off_grid;
    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] scan_idx;

    assign cur_x = seg_x_q[head_ptr_q];
    assign cur_y = seg_y_q[head_ptr_q];

    // A legal request arriving with the tick steers that very step.
    assign dir_ok   = dir_valid && (dir != opposite(dir_q));
    assign eff_dir  = dir_ok ? dir : pend_q;
    // In RUN the step about to be taken uses eff_dir; in MOVE it has
    // already been committed into dir_q.
    assign step_dir = (state_q == ST_RUN) ? eff_dir : dir_q;

    assign ptr_inc  = (head_ptr_q == PW'(MAX_LEN - 1)) ? '0 : head_ptr_q + PW'(1);
    assign scan_idx = ring_back(head_ptr_q, scan_i_q);

    always_comb begin
        nxt_x    = cur_x;
        nxt_y    = cur_y;
        off_grid = 1'b0;
        case (step_dir)
            DIR_UP: begin
                if (cur_y == '0) off_grid = 1'b1;
                else             nxt_y = cur_y - YW'(1);
            end
            DIR_DOWN: begin
                if (cur_y == YW'(GRID_H - 1)) off_grid = 1'b1;
                else                          nxt_y = cur_y + YW'(1);
            end
            DIR_LEFT: begin
                if (cur_x == '0) off_grid = 1'b1;
                else             nxt_x = cur_x - XW'(1);
            end
            default: begin
                if (cur_x == XW'(GRID_W - 1)) off_grid = 1'b1;
                else                          nxt_x = cur_x + XW'(1);
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        grow_pend_d = grow_pend_q;
        head_ptr_d  = head_ptr_q;
        length_d    = length_q;
        scan_i_d    = scan_i_q;
        seg_x_d     = seg_x_q;
        seg_y_d     = seg_y_q;
        died_d      = 1'b0;

        if (dir_ok) begin
            pend_d = dir;
        end
        if (grow) begin
            grow_pend_d = 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (tick) begin
                    dir_d  = eff_dir;
                    pend_d = eff_dir;
                    if (off_grid) begin
                        state_d = ST_DEAD;
                        died_d  = 1'b1;
                    end else begin
                        state_d = ST_MOVE;
                    end
                end
            end
            ST_MOVE: begin
                head_ptr_d       = ptr_inc;
                seg_x_d[ptr_inc] = nxt_x;
                seg_y_d[ptr_inc] = nxt_y;
                if (grow_pend_q && (int'(length_q) < MAX_LEN)) begin
                    length_d = length_q + LW'(1);
                end
                // The pending request is consumed; only a pulse arriving in
                // this very cycle survives to the next step.
                grow_pend_d = grow;
                scan_i_d    = LW'(1);
                state_d     = ST_SCAN;
            end
            ST_SCAN: begin
                if ((seg_x_q[scan_idx] == cur_x) && (seg_y_q[scan_idx] == cur_y)) begin
                    state_d = ST_DEAD;
                    died_d  = 1'b1;
                end else if (scan_i_q == length_q - LW'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    scan_i_d = scan_i_q + LW'(1);
                end
            end
            default: begin
                // IDLE / DEAD: ticks ignored, wait for start.
            end
        endcase

        // Start overrides anything that happened above this cycle.
        if (start) begin
            state_d     = ST_RUN;
            dir_d       = DIR_RIGHT;
            pend_d      = DIR_RIGHT;
            grow_pend_d = 1'b0;
            head_ptr_d  = '0;
            length_d    = LW'(INIT_LEN);
            scan_i_d    = '0;
            seg_x_d     = layout_x();
            seg_y_d     = layout_y();
            died_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            grow_pend_q <= 1'b0;
            head_ptr_q  <= '0;
            length_q    <= LW'(INIT_LEN);
            scan_i_q    <= '0;
            seg_x_q     <= layout_x();
            seg_y_q     <= layout_y();
            died_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            grow_pend_q <= grow_pend_d;
            head_ptr_q  <= head_ptr_d;
            length_q    <= length_d;
            scan_i_q    <= scan_i_d;
            seg_x_q     <= seg_x_d;
            seg_y_q     <= seg_y_d;
            died_q      <= died_d;
        end
    end

    snake_cell_match #(
        .MAX_LEN (MAX_LEN),
        .XW      (XW),
        .YW      (YW),
        .PW      (PW),
        .LW      (LW)
    ) u_query (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_x      (seg_x_q),
        .seg_y      (seg_y_q),
        .head_ptr   (head_ptr_q),
        .length     (length_q),
        .q_x        (q_x),
        .q_y        (q_y),
        .q_hit_head (q_hit_head),
        .q_hit_body (q_hit_body)
    );

    assign head_x = cur_x;
    assign head_y = cur_y;
    assign length = length_q;
    assign busy   = (state_q == ST_MOVE) || (state_q == ST_SCAN);
    assign dead   = (state_q == ST_DEAD);
    assign died   = died_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_engine
// Purpose  : Self-checking bench for snake_engine. A queue-based model of
//            the snake (head at index 0) predicts position, length, death
//            and query answers for directed and random step sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_engine;

    localparam int GW = 64;
    localparam int GH = 48;
    localparam int ML = 32;
    localparam int IL = 4;
    localparam int XW = 6;
    localparam int YW = 6;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          tick;
    logic          dir_valid;
    logic [1:0]    dir;
    logic          grow;
    logic [XW-1:0] q_x;
    logic [YW-1:0] q_y;
    logic          q_hit_head;
    logic          q_hit_body;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [LW-1:0] length;
    logic          busy;
    logic          dead;
    logic          died;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: body cells, head first; mode 0 idle, 1 running, 2 dead.
    int bx[$];
    int by[$];
    int m_dir, m_pend, m_mode;
    bit m_gp;

    always #5 clk = ~clk;

    snake_engine #(
        .GRID_W   (GW),
        .GRID_H   (GH),
        .MAX_LEN  (ML),
        .INIT_LEN (IL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .tick       (tick),
        .dir_valid  (dir_valid),
        .dir        (dir),
        .grow       (grow),
        .q_x        (q_x),
        .q_y        (q_y),
        .q_hit_head (q_hit_head),
        .q_hit_body (q_hit_body),
        .head_x     (head_x),
        .head_y     (head_y),
        .length     (length),
        .busy       (busy),
        .dead       (dead),
        .died       (died)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        bx.delete();
        by.delete();
        for (int k = 0; k < IL; k++) begin
            bx.push_back(IL - 1 - k);
            by.push_back(GH / 2);
        end
        m_dir  = 3;
        m_pend = 3;
        m_gp   = 1'b0;
    endfunction

    // Encoding pairs up/down and left/right, so reversal flips bit 0.
    function automatic void model_dirv(input int d);
        if (d != (m_dir ^ 1)) m_pend = d;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_head_x"}, int'(head_x), bx[0]);
        check({tag, "_head_y"}, int'(head_y), by[0]);
        check({tag, "_length"}, int'(length), bx.size());
        check({tag, "_dead"},   int'(dead),   (m_mode == 2) ? 1 : 0);
        check({tag, "_busy"},   int'(busy),   0);
    endtask

    task automatic query(input int x, input int y);
        int eb;
        q_x = x[XW-1:0];
        q_y = y[YW-1:0];
        cyc();
        eb = 0;
        for (int k = 1; k < bx.size(); k++) begin
            if (bx[k] == x && by[k] == y) eb = 1;
        end
        check("q_head", int'(q_hit_head), (bx[0] == x && by[0] == y) ? 1 : 0);
        check("q_body", int'(q_hit_body), eb);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        model_reset();
        m_mode = 1;
        check_state("start");
    endtask

    // One tick with optional direction/grow, optionally a second tick (and
    // direction) one cycle later that must be dropped. Waits for the step
    // to settle and checks the result against the model.
    task automatic step(input bit dv, input int d, input bit g,
                        input bit drop, input bit dv2, input int d2);
        int died_exp;
        int died_cnt;
        int win;
        int nx, ny;
        bit off;
        died_exp  = 0;
        win       = 1;
        tick      = 1'b1;
        dir_valid = dv;
        dir       = d[1:0];
        grow      = g;
        cyc();
        tick      = 1'b0;
        dir_valid = 1'b0;
        grow      = 1'b0;
        if (dv) model_dirv(d);
        if (g) m_gp = 1'b1;
        if (m_mode == 1) begin
            m_dir = m_pend;
            nx  = bx[0];
            ny  = by[0];
            off = 1'b0;
            case (m_dir)
                0: if (ny == 0)      off = 1'b1; else ny = ny - 1;
                1: if (ny == GH - 1) off = 1'b1; else ny = ny + 1;
                2: if (nx == 0)      off = 1'b1; else nx = nx - 1;
                default: if (nx == GW - 1) off = 1'b1; else nx = nx + 1;
            endcase
            if (off) begin
                m_mode   = 2;
                died_exp = 1;
            end else begin
                bx.push_front(nx);
                by.push_front(ny);
                if (!(m_gp && bx.size() <= ML)) begin
                    void'(bx.pop_back());
                    void'(by.pop_back());
                end
                m_gp = 1'b0;
                for (int k = 1; k < bx.size(); k++) begin
                    if (bx[k] == nx && by[k] == ny) begin
                        m_mode   = 2;
                        died_exp = 1;
                    end
                end
                win = bx.size() + 1;
                check("busy_after_tick", int'(busy), 1);
            end
        end
        died_cnt = int'(died);
        for (int c = 1; c <= win; c++) begin
            if (c == 1 && drop) begin
                tick = 1'b1;
                if (dv2) begin
                    dir_valid = 1'b1;
                    dir       = d2[1:0];
                end
            end
            cyc();
            tick      = 1'b0;
            dir_valid = 1'b0;
            if (c == 1 && drop && dv2) model_dirv(d2);
            died_cnt += int'(died);
        end
        check("died_pulses", died_cnt, died_exp);
        check_state("step");
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        start     = 1'b0;
        tick      = 1'b0;
        dir_valid = 1'b0;
        dir       = 2'b00;
        grow      = 1'b0;
        q_x       = '0;
        q_y       = '0;
        model_reset();
        m_mode = 0;
        #23;
        check("rst_q_head", int'(q_hit_head), 0);
        check("rst_died",   int'(died),       0);
        check_state("reset");
        rst_n = 1'b1;
        cyc();

        // Reset layout visible through the query port; ticks ignored in IDLE.
        query(0, 24);
        check("rst_q_tail_body", int'(q_hit_body), 1);
        query(3, 24);
        check("rst_q_head_hit", int'(q_hit_head), 1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

        // Three plain steps right.
        do_start();
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        check("three_steps_x", int'(head_x), 6);
        query(2, 24);
        query(3, 24);

        // Reverse rejected, up accepted, tick while busy dropped.
        step(1'b1, 2, 1'b0, 1'b0, 1'b0, 0);
        check("reverse_rejected_x", int'(head_x), 7);
        step(1'b1, 0, 1'b0, 1'b0, 1'b0, 0);
        check("up_y", int'(head_y), 23);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
        check("drop_y", int'(head_y), 22);

        // Grow to the maximum, then drive into the right wall.
        do_start();
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
        check("grow_len5", int'(length), 5);
        query(0, 24);
        for (int i = 0; i < 39; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
        check("len_capped", int'(length), ML);
        while (m_mode == 1 && bx[0] < GW - 1) step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        check("at_wall_x", int'(head_x), GW - 1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        check("wall_dead", int'(dead), 1);
        check("wall_keep_x", int'(head_x), GW - 1);
        query(GW - 2, 24);
        do_start();

        // Tight turn into own body.
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 0, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 2, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1, 1'b0, 1'b0, 1'b0, 0);
        check("self_hit_dead", int'(dead), 1);

        // Asynchronous reset in the middle of a scan.
        do_start();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        #2;
        model_reset();
        m_mode = 0;
        check_state("midscan_reset");
        rst_n = 1'b1;
        cyc();

        // Random play.
        do_start();
        for (int i = 0; i < 150; i++) begin
            if (m_mode != 1 && ($urandom_range(0, 1) == 1)) begin
                do_start();
            end
            step(($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)));
            k = int'($urandom_range(0, bx.size() - 1));
            query(bx[k], by[k]);
            query(int'($urandom_range(0, GW - 1)), int'($urandom_range(0, GH - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
